// File: rtl/adder_chk_pkg.sv
// Shared definitions for the adder response checker.
// Contents:
//   chk_state_t      - control FSM states (IDLE/RUN/DRAIN/DONE, 2-bit)
//   DEF_WIDTH        - default operand/sum width
//   DEF_NUM_SAMPLES  - default tuples per check run
//   DEF_CNT_W        - default counter/index width
//   PIPE_DEPTH       - compare pipeline depth; sets the DRAIN length
package adder_chk_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } chk_state_t;

  localparam int unsigned DEF_WIDTH       = 8;
  localparam int unsigned DEF_NUM_SAMPLES = 256;
  localparam int unsigned DEF_CNT_W       = 16;
  localparam int unsigned PIPE_DEPTH      = 2;

endpackage

// File: rtl/adder_golden.sv
// Golden reference for the adder under test.
// Recomputes A + B + Cin at WIDTH+1 bits (zero-extended) and flags any
// difference from the observed {carry, sum}. Purely combinational.
// Ports:
//   a, b      in  WIDTH  operands applied to the adder
//   cin       in  1      carry-in applied to the adder
//   sum       in  WIDTH  observed adder sum
//   carry     in  1      observed adder carry-out
//   mismatch  out 1      observed result differs from the reference
module adder_golden #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic [WIDTH-1:0] sum,
  input  logic             carry,
  output logic             mismatch
);

  logic [WIDTH:0] golden;

  always_comb begin
    golden   = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
    mismatch = ({carry, sum} != golden);
  end

endmodule

// File: rtl/adder_response_checker.sv
// Adder response checker.
// Consumes operand/result tuples from an adder under test, recomputes the
// golden result and accumulates pass/fail statistics over a run of
// NUM_SAMPLES tuples. Two-stage pipeline: stage 1 registers the accepted
// tuple and its index, stage 2 compares and updates the error statistics.
// Ports:
//   clk, rst_n        clock (rising edge), async active-low reset
//   Start             pulse; begins a run from IDLE or DONE
//   Valid             tuple on A/B/Cin/Sum/Carry is valid
//   A, B, Cin         operands applied to the adder
//   Sum, Carry        adder outputs
//   Ready             tuple accepted this cycle when Valid is high
//   Busy              run in progress (RUN or DRAIN)
//   Done              run complete; held until next Start
//   Pass              while Done: no mismatches seen
//   Err_count         mismatching tuples, saturating
//   Sample_count      tuples accepted this run
//   First_fail_valid  a mismatch has been captured
//   First_fail_idx    0-based index of the first mismatching tuple
module adder_response_checker
  import adder_chk_pkg::*;
#(
  parameter int unsigned WIDTH       = DEF_WIDTH,
  parameter int unsigned NUM_SAMPLES = DEF_NUM_SAMPLES,
  parameter int unsigned CNT_W       = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             Start,
  input  logic             Valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic [WIDTH-1:0] Sum,
  input  logic             Carry,
  output logic             Ready,
  output logic             Busy,
  output logic             Done,
  output logic             Pass,
  output logic [CNT_W-1:0] Err_count,
  output logic [CNT_W-1:0] Sample_count,
  output logic             First_fail_valid,
  output logic [CNT_W-1:0] First_fail_idx
);

  localparam int unsigned DRAIN_W = (PIPE_DEPTH > 1) ? $clog2(PIPE_DEPTH) : 1;

  chk_state_t state, state_nxt;

  logic               accept;
  logic               start_run;
  logic               last_accept;
  logic [DRAIN_W-1:0] drain_cnt;
  logic [CNT_W-1:0]   sample_cnt;

  // Stage 1: captured tuple and its index within the run
  logic               s1_valid;
  logic [WIDTH-1:0]   s1_a;
  logic [WIDTH-1:0]   s1_b;
  logic               s1_cin;
  logic [WIDTH-1:0]   s1_sum;
  logic               s1_carry;
  logic [CNT_W-1:0]   s1_idx;
  logic               s1_mismatch;

  // Stage 2: error statistics
  logic [CNT_W-1:0]   err_cnt;
  logic               ff_valid;
  logic [CNT_W-1:0]   ff_idx;

  assign accept      = Valid && (state == RUN);
  assign start_run   = Start && ((state == IDLE) || (state == DONE));
  assign last_accept = accept && (sample_cnt == CNT_W'(NUM_SAMPLES - 1));

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // FSM: next state
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start_run) state_nxt = RUN;
      RUN:     if (last_accept) state_nxt = DRAIN;
      // The counter times the pipeline depth; s1_valid guards against
      // leaving while a tuple is still in flight.
      DRAIN:   if ((drain_cnt == '0) && !s1_valid) state_nxt = DONE;
      DONE:    if (start_run) state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    Ready = (state == RUN);
    Busy  = (state == RUN) || (state == DRAIN);
    Done  = (state == DONE);
    Pass  = (state == DONE) && (err_cnt == '0);
  end

  // Run counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_cnt <= '0;
      drain_cnt  <= '0;
    end else begin
      if (start_run)   sample_cnt <= '0;
      else if (accept) sample_cnt <= sample_cnt + 1'b1;

      if (last_accept)
        drain_cnt <= DRAIN_W'(PIPE_DEPTH - 1);
      else if ((state == DRAIN) && (drain_cnt != '0))
        drain_cnt <= drain_cnt - 1'b1;
    end
  end

  // Stage 1: register the accepted tuple
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_cin   <= 1'b0;
      s1_sum   <= '0;
      s1_carry <= 1'b0;
      s1_idx   <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_a     <= A;
        s1_b     <= B;
        s1_cin   <= Cin;
        s1_sum   <= Sum;
        s1_carry <= Carry;
        s1_idx   <= sample_cnt;
      end
    end
  end

  adder_golden #(
    .WIDTH(WIDTH)
  ) u_golden (
    .a        (s1_a),
    .b        (s1_b),
    .cin      (s1_cin),
    .sum      (s1_sum),
    .carry    (s1_carry),
    .mismatch (s1_mismatch)
  );

  // Stage 2: compare and accumulate. A Start can only be taken with the
  // pipeline empty, so clearing never races a pending compare.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt  <= '0;
      ff_valid <= 1'b0;
      ff_idx   <= '0;
    end else if (start_run) begin
      err_cnt  <= '0;
      ff_valid <= 1'b0;
      ff_idx   <= '0;
    end else if (s1_valid && s1_mismatch) begin
      if (err_cnt != '1) err_cnt <= err_cnt + 1'b1;
      if (!ff_valid) begin
        ff_valid <= 1'b1;
        ff_idx   <= s1_idx;
      end
    end
  end

  assign Err_count        = err_cnt;
  assign Sample_count     = sample_cnt;
  assign First_fail_valid = ff_valid;
  assign First_fail_idx   = ff_idx;

endmodule

// File: tb/tb_adder_response_checker.sv
module tb_adder_response_checker;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       valid;
  logic [7:0] a, b, sum;
  logic       cin, carry;

  // Instances 0..2: CNT_W=16 with NUM_SAMPLES 4/256/16; instance 3: CNT_W=2, NUM_SAMPLES=3
  logic        start [4];
  logic        rdy   [4];
  logic        bsy   [4];
  logic        dn    [4];
  logic        ps    [4];
  logic        ffv   [4];
  logic [15:0] errc  [4];
  logic [15:0] scnt  [4];
  logic [15:0] ffi   [4];
  logic [1:0]  e3, s3, f3;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int last_acc = 0;

  typedef struct {
    int inst;
    int err;
    int sc;
    int ffv;
    int ffi;
    int pss;
    int dcyc;
  } exp_t;

  exp_t expq[$];
  logic pdone[4] = '{1'b0, 1'b0, 1'b0, 1'b0};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    adder_response_checker #(
      .WIDTH       (8),
      .NUM_SAMPLES ((g == 0) ? 4 : (g == 1) ? 256 : 16),
      .CNT_W       (16)
    ) u_dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .Start            (start[g]),
      .Valid            (valid),
      .A                (a),
      .B                (b),
      .Cin              (cin),
      .Sum              (sum),
      .Carry            (carry),
      .Ready            (rdy[g]),
      .Busy             (bsy[g]),
      .Done             (dn[g]),
      .Pass             (ps[g]),
      .Err_count        (errc[g]),
      .Sample_count     (scnt[g]),
      .First_fail_valid (ffv[g]),
      .First_fail_idx   (ffi[g])
    );
  end

  adder_response_checker #(
    .WIDTH       (8),
    .NUM_SAMPLES (3),
    .CNT_W       (2)
  ) u_dut3 (
    .clk              (clk),
    .rst_n            (rst_n),
    .Start            (start[3]),
    .Valid            (valid),
    .A                (a),
    .B                (b),
    .Cin              (cin),
    .Sum              (sum),
    .Carry            (carry),
    .Ready            (rdy[3]),
    .Busy             (bsy[3]),
    .Done             (dn[3]),
    .Pass             (ps[3]),
    .Err_count        (e3),
    .Sample_count     (s3),
    .First_fail_valid (ffv[3]),
    .First_fail_idx   (f3)
  );

  assign errc[3] = {14'd0, e3};
  assign scnt[3] = {14'd0, s3};
  assign ffi[3]  = {14'd0, f3};

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  task automatic chk_zero(input int i, input string tag);
    chk({tag, "_ready"}, int'(rdy[i]), 0);
    chk({tag, "_busy"},  int'(bsy[i]), 0);
    chk({tag, "_done"},  int'(dn[i]),  0);
    chk({tag, "_pass"},  int'(ps[i]),  0);
    chk({tag, "_err"},   int'(errc[i]), 0);
    chk({tag, "_scnt"},  int'(scnt[i]), 0);
    chk({tag, "_ffv"},   int'(ffv[i]), 0);
    chk({tag, "_ffi"},   int'(ffi[i]), 0);
  endtask

  // Drive one tuple from a correct adder (optionally with Sum bit0 flipped)
  // and advance past the sampling edge.
  task automatic send(input int av, input int bv, input int cv, input bit flip);
    logic [8:0] r;
    a     = 8'(av);
    b     = 8'(bv);
    cin   = cv[0];
    r     = {1'b0, a} + {1'b0, b} + {8'd0, cin};
    carry = r[8];
    sum   = r[7:0] ^ {7'd0, flip};
    valid = 1'b1;
    @(posedge clk);
    #1;
    last_acc = cyc;
  endtask

  task automatic do_start(input int i);
    start[i] = 1'b1;
    @(posedge clk);
    #1;
    start[i] = 1'b0;
  endtask

  task automatic push_exp(input int inst, input int err, input int sc,
                          input int fv, input int fi, input int pss);
    exp_t e;
    e.inst = inst; e.err = err; e.sc = sc; e.ffv = fv; e.ffi = fi; e.pss = pss;
    e.dcyc = last_acc + 2;
    expq.push_back(e);
  endtask

  task automatic wait_done(input int i);
    for (int k = 0; k < 10 && !dn[i]; k++) begin
      @(posedge clk);
      #1;
    end
    if (!dn[i]) begin
      checks++;
      failures++;
      $display("FAIL done_timeout inst=%0d actual=0 expected=1", i);
    end
    @(negedge clk);
    #1;
  endtask

  // Monitor: pops the expected run result whenever a Done rises
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (dn[i] && !pdone[i]) begin
        if (expq.size() == 0) begin
          chk("unexpected_done", i, -1);
        end else begin
          exp_t e;
          e = expq.pop_front();
          chk("mon_inst",     i,              e.inst);
          chk("mon_done_cyc", cyc,            e.dcyc);
          chk("mon_err",      int'(errc[i]),  e.err);
          chk("mon_scnt",     int'(scnt[i]),  e.sc);
          chk("mon_ffv",      int'(ffv[i]),   e.ffv);
          if (e.ffv != 0) chk("mon_ffi", int'(ffi[i]), e.ffi);
          chk("mon_pass",     int'(ps[i]),    e.pss);
          chk("mon_busy",     int'(bsy[i]),   0);
        end
      end
      pdone[i] = dn[i];
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    valid = 1'b0;
    a = '0; b = '0; cin = 1'b0; sum = '0; carry = 1'b0;
    for (int i = 0; i < 4; i++) start[i] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_zero(0, "rst0");
    chk_zero(3, "rst3");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 4-sample run, correct adder
    do_start(0);
    chk("run_ready", int'(rdy[0]), 1);
    chk("run_busy",  int'(bsy[0]), 1);
    send(0, 0, 0, 0);
    send(0, 1, 0, 0);
    send(1, 0, 0, 0);
    send(1, 1, 0, 0);
    push_exp(0, 0, 4, 0, 0, 1);
    chk("ready_drop", int'(rdy[0]), 0);
    chk("drain_busy", int'(bsy[0]), 1);
    valid = 1'b0;
    wait_done(0);

    // 256-sample run: A=0..255, B=255, Cin=1
    do_start(1);
    for (int i = 0; i < 256; i++) send(i, 255, 1, 0);
    push_exp(1, 0, 256, 0, 0, 1);
    valid = 1'b0;
    wait_done(1);

    // Faults at indices 5 and 9
    do_start(2);
    for (int i = 0; i < 16; i++) begin
      send(i * 3, i * 7, i & 1, (i == 5) || (i == 9));
      if (i == 5) chk("ffv_early", int'(ffv[2]), 0);
      if (i == 6) begin
        chk("ffv_latency", int'(ffv[2]), 1);
        chk("ffi_latency", int'(ffi[2]), 5);
        chk("err_latency", int'(errc[2]), 1);
      end
    end
    push_exp(2, 2, 16, 1, 5, 0);
    valid = 1'b0;
    wait_done(2);

    // Start and Valid together in DONE: Start wins
    start[2] = 1'b1;
    send(9, 9, 0, 0);
    start[2] = 1'b0;
    chk("start_wins_scnt",  int'(scnt[2]), 0);
    chk("start_wins_ready", int'(rdy[2]),  1);
    chk("start_wins_err",   int'(errc[2]), 0);

    // Valid toggled 1/0, then held high through DRAIN and DONE
    for (int k = 0; k < 15; k++) begin
      send(k + 100, k, 0, 0);
      valid = 1'b0;
      @(posedge clk);
      #1;
    end
    send(200, 100, 1, 0);
    push_exp(2, 0, 16, 0, 0, 1);
    repeat (6) @(posedge clk);
    #1;
    chk("hold_valid_done", int'(dn[2]),   1);
    chk("hold_valid_scnt", int'(scnt[2]), 16);
    valid = 1'b0;

    // Reset mid-run after 3 accepts with 1 error
    do_start(2);
    send(1, 2, 0, 0);
    send(3, 4, 0, 1);
    send(5, 6, 0, 0);
    valid = 1'b0;
    @(posedge clk);
    #1;
    chk("pre_reset_err",  int'(errc[2]), 1);
    chk("pre_reset_scnt", int'(scnt[2]), 3);
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero(2, "async_rst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    do_start(2);
    for (int i = 0; i < 16; i++) send(255 - i, i * 11, (i >> 1) & 1, 0);
    push_exp(2, 0, 16, 0, 0, 1);
    valid = 1'b0;
    wait_done(2);

    // CNT_W=2, NUM_SAMPLES=3, every result wrong; mid-run Start ignored
    do_start(3);
    send(1, 1, 0, 1);
    start[3] = 1'b1;
    send(2, 2, 0, 1);
    start[3] = 1'b0;
    chk("start_ignored_scnt", int'(scnt[3]), 2);
    chk("start_ignored_busy", int'(bsy[3]),  1);
    send(3, 3, 1, 1);
    push_exp(3, 3, 3, 1, 0, 0);
    valid = 1'b0;
    wait_done(3);

    do_start(3);
    chk("restart_err",  int'(errc[3]), 0);
    chk("restart_scnt", int'(scnt[3]), 0);
    chk("restart_ffv",  int'(ffv[3]),  0);
    chk("restart_done", int'(dn[3]),   0);
    send(128, 128, 0, 1);
    send(255, 0, 1, 1);
    send(7, 9, 1, 1);
    push_exp(3, 3, 3, 1, 0, 0);
    valid = 1'b0;
    wait_done(3);

    chk("scoreboard_left", expq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
